// File: rtl/score_board.sv
// Player score accumulator with iterative binary-to-BCD conversion and
// a 4-digit multiplexed 7-segment display driver with leading-zero blanking.
module score_board #(
  parameter int unsigned SCORE_W      = 14,
  parameter int unsigned MAX_SCORE    = 9999,
  parameter int unsigned REFRESH_BITS = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         hit,
  input  logic               clr_score,
  output logic [SCORE_W-1:0] score,
  output logic               busy,
  output logic               bcd_valid,
  output logic [3:0]         digit_an,
  output logic [6:0]         seg
);

  localparam int unsigned CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam logic [SCORE_W:0] MAX_EXT = (SCORE_W+1)'(MAX_SCORE);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                  state_q;
  logic [2:0]              hit_q;
  logic [SCORE_W-1:0]      score_q, score_d;
  logic [SCORE_W-1:0]      conv_src_q, src_q, snap_q;
  logic [15:0]             work_q, work_adj, bcd_q;
  logic [CNT_W-1:0]        shift_cnt_q;
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [3:0]              an_q, an_d;
  logic [6:0]              seg_q, seg_d;

  logic [2:0]         new_hit;
  logic [1:0]         inc;
  logic [SCORE_W:0]   sum;

  // Hit scoring: rising edges only, saturating sum computed one bit wider.
  always_comb begin
    new_hit = hit & ~hit_q;
    inc     = {1'b0, new_hit[0]} + {1'b0, new_hit[1]} + {1'b0, new_hit[2]};
    sum     = {1'b0, score_q} + (SCORE_W+1)'(inc);
    score_d = score_q;
    if (clr_score) begin
      score_d = '0;
    end else if (sum > MAX_EXT) begin
      score_d = MAX_EXT[SCORE_W-1:0];
    end else begin
      score_d = sum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q   <= '1;
      score_q <= '0;
    end else begin
      hit_q   <= hit;
      score_q <= score_d;
    end
  end

  always_comb begin
    work_adj = work_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
  end

  // snap_q is consumed by the shift, so src_q keeps the converted value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      conv_src_q  <= '0;
      src_q       <= '0;
      snap_q      <= '0;
      work_q      <= '0;
      shift_cnt_q <= '0;
      bcd_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (score_q != conv_src_q) state_q <= LOAD;
        LOAD: begin
          snap_q      <= score_q;
          src_q       <= score_q;
          work_q      <= '0;
          shift_cnt_q <= '0;
          state_q     <= SHIFT;
        end
        SHIFT: begin
          work_q      <= {work_adj[14:0], snap_q[SCORE_W-1]};
          snap_q      <= {snap_q[SCORE_W-2:0], 1'b0};
          shift_cnt_q <= shift_cnt_q + 1'b1;
          if (shift_cnt_q == CNT_W'(SCORE_W-1)) state_q <= DONE;
        end
        DONE: begin
          bcd_q      <= work_q;
          conv_src_q <= src_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  logic [1:0] sel;
  logic [3:0] blank;
  logic [3:0] nib;

  always_comb begin
    sel      = refresh_q[REFRESH_BITS-1 -: 2];
    blank[3] = (bcd_q[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd_q[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd_q[7:4] == 4'd0);
    blank[0] = 1'b0;
    case (sel)
      2'd0:    nib = bcd_q[3:0];
      2'd1:    nib = bcd_q[7:4];
      2'd2:    nib = bcd_q[11:8];
      default: nib = bcd_q[15:12];
    endcase
    an_d  = '1;
    seg_d = 7'h7F;
    if (!blank[sel]) begin
      an_d[sel] = 1'b0;
      seg_d     = seg_code(nib);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_q <= '0;
      an_q      <= 4'b1110;
      seg_q     <= 7'h40;
    end else begin
      refresh_q <= refresh_q + 1'b1;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign score     = score_q;
  assign busy      = (state_q != IDLE);
  assign bcd_valid = (state_q == IDLE) && (conv_src_q == score_q);
  assign digit_an  = an_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_score_board.sv
// Scoreboard bench for score_board: stimulus pushes expected settled scores,
// a forked monitor checks each completed conversion and every busy window.
module tb_score_board;

  localparam int unsigned SW = 14;
  localparam int unsigned RB = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    hit;
  logic          clr_score;
  logic [SW-1:0] score;
  logic          busy;
  logic          bcd_valid;
  logic [3:0]    digit_an;
  logic [6:0]    seg;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  score_board #(.SCORE_W(SW), .MAX_SCORE(9999), .REFRESH_BITS(RB)) dut (
    .clk(clk), .rst(rst), .hit(hit), .clr_score(clr_score),
    .score(score), .busy(busy), .bcd_valid(bcd_valid),
    .digit_an(digit_an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [2:0] h);
    hit = h;
    step(1);
    hit = 3'b000;
    step(1);
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      step(1);
      n++;
    end
    check(name, exp_q.size(), 0);
    step(2);
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'd0: seg_ref = 7'h40;  4'd1: seg_ref = 7'h79;
      4'd2: seg_ref = 7'h24;  4'd3: seg_ref = 7'h30;
      4'd4: seg_ref = 7'h19;  4'd5: seg_ref = 7'h12;
      4'd6: seg_ref = 7'h02;  4'd7: seg_ref = 7'h78;
      4'd8: seg_ref = 7'h00;  4'd9: seg_ref = 7'h10;
      default: seg_ref = 7'h7F;
    endcase
  endfunction

  // Observe a full refresh sweep and compare against the expected digits.
  task automatic check_display(input string tag, input logic [15:0] d);
    logic [6:0] sv [4];
    bit         lit [4];
    bit         bseen = 0, bbad = 0, blank_exp [4];
    int         idx;
    for (int i = 0; i < 4; i++) begin
      sv[i] = 7'h7F;
      lit[i] = 0;
    end
    blank_exp[3] = (d[15:12] == 0);
    blank_exp[2] = blank_exp[3] && (d[11:8] == 0);
    blank_exp[1] = blank_exp[2] && (d[7:4] == 0);
    blank_exp[0] = 0;
    repeat (4 * (1 << (RB - 2)) + 8) begin
      @(negedge clk);
      idx = -1;
      case (digit_an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        4'b1111: begin
          bseen = 1;
          if (seg != 7'h7F) bbad = 1;
        end
        default: bbad = 1;
      endcase
      if (idx >= 0) begin
        lit[idx] = 1;
        sv[idx]  = seg;
      end
    end
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_lit%0d", tag, i), int'(lit[i]), int'(!blank_exp[i]));
      if (!blank_exp[i]) check($sformatf("%s_seg%0d", tag, i), sv[i], seg_ref(d[4*i +: 4]));
    end
    check({tag, "_blank_bad"}, int'(bbad), 0);
    check({tag, "_blank_seen"}, int'(bseen), int'(blank_exp[1]));
  endtask

  initial begin
    rst = 1'b0;
    hit = 3'b000;
    clr_score = 1'b0;

    // Monitor: every busy window is 16 cycles; a settled conversion pops one expectation.
    fork
      begin
        int run = 0;
        bit prev = 0;
        int e;
        forever begin
          @(negedge clk);
          if (!rst) begin
            run = 0;
            prev = 0;
          end else begin
            if (busy) begin
              run++;
            end else begin
              if (prev) begin
                check("busy_len", run, 16);
                if (bcd_valid) begin
                  if (exp_q.size() == 0) begin
                    check("unexpected_settle", int'(score), -1);
                  end else begin
                    e = exp_q.pop_front();
                    check("settle_score", int'(score), e);
                  end
                end
              end
              run = 0;
            end
            prev = busy;
          end
        end
      end
    join_none

    // Reset state
    #23;
    check("rst_score", int'(score), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(bcd_valid), 1);
    check("rst_an", int'(digit_an), 4'b1110);
    check("rst_seg", int'(seg), 7'h40);
    step(1);
    rst = 1'b1;
    step(50);
    check("idle_score", int'(score), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_valid", int'(bcd_valid), 1);
    check_display("disp0", 16'h0000);

    // Single pulse, then a held level counts once
    exp_q.push_back(1);
    pulse(3'b001);
    drain("drain_1", 40);
    exp_q.push_back(2);
    hit = 3'b010;
    step(100);
    hit = 3'b000;
    step(1);
    drain("drain_2", 10);
    check("score_2_valid", int'(bcd_valid), 1);
    check_display("disp2", 16'h0002);

    // Three simultaneous edges add 3 in one cycle
    exp_q.push_back(5);
    hit = 3'b111;
    step(1);
    check("plus3", int'(score), 5);
    hit = 3'b000;
    drain("drain_5", 40);

    // Clear wins over a coincident edge
    exp_q.push_back(0);
    clr_score = 1'b1;
    hit = 3'b001;
    step(1);
    check("clr_prio", int'(score), 0);
    clr_score = 1'b0;
    hit = 3'b000;
    drain("drain_clr", 40);
    check_display("disp_clr", 16'h0000);

    // Preload to 9998, then saturate
    for (int i = 0; i < 3332; i++) pulse(3'b111);
    pulse(3'b011);
    check("preload", int'(score), 9998);
    exp_q.push_back(9998);
    drain("drain_9998", 60);
    exp_q.push_back(9999);
    pulse(3'b111);
    check("saturate", int'(score), 9999);
    drain("drain_9999", 40);
    check_display("disp9999", 16'h9999);
    pulse(3'b111);
    step(30);
    check("sat_hold", int'(score), 9999);
    check("sat_idle", int'(busy), 0);

    // Edges 5 cycles apart: one restart, a single settle at the end
    exp_q.push_back(0);
    clr_score = 1'b1;
    step(1);
    clr_score = 1'b0;
    drain("drain_clr2", 40);
    exp_q.push_back(2);
    pulse(3'b001);
    step(3);
    pulse(3'b010);
    drain("drain_restart", 45);
    check_display("disp_restart", 16'h0002);

    // Reset during SHIFT at 1234
    for (int i = 0; i < 410; i++) pulse(3'b111);
    pulse(3'b001);
    exp_q.push_back(1233);
    drain("drain_1233", 60);
    hit = 3'b001;
    step(1);
    hit = 3'b000;
    check("score_1234", int'(score), 1234);
    step(4);
    check("mid_busy", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    check("arst_score", int'(score), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_valid", int'(bcd_valid), 1);
    check("arst_an", int'(digit_an), 4'b1110);
    check("arst_seg", int'(seg), 7'h40);
    step(3);
    rst = 1'b1;
    step(40);
    check("post_score", int'(score), 0);
    check("post_busy", int'(busy), 0);
    check("post_valid", int'(bcd_valid), 1);
    check_display("disp_post", 16'h0000);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/score_board.md
Name: score_board

Overview:
- Downstream consumer of the game's per-dragon hit events (Event[3:1]).
- Accumulates the player score, converts it to BCD with an iterative shift-add-3 engine, and drives the board's 4-digit multiplexed 7-segment display.
- Replaces the bare integer score counter in the top level with a bounded, displayable score.

Parameters:
- SCORE_W, 14, width of binary score register.
- MAX_SCORE, 9999, saturation value; must fit in SCORE_W and in 4 BCD digits.
- REFRESH_BITS, 17, width of display refresh counter; top 2 bits select the digit (~763 Hz digit rate at 100 MHz).

Ports:
- clk  in  1  system clock (100 MHz board clock).
- rst  in  1  reset, asynchronous, active-low.
- hit  in  3  dragon hit flags (Event[3:1]); level signals, may stay high for many cycles.
- clr_score  in  1  synchronous score clear, active-high.
- score  out  SCORE_W  current binary score.
- busy  out  1  BCD conversion in progress.
- bcd_valid  out  1  displayed BCD equals current score.
- digit_an  out  4  digit anodes, active-low; bit 0 = ones digit.
- seg  out  7  segments, active-low, ordered {g,f,e,d,c,b,a}.

Behaviour:
- Reset is asynchronous and active-low. While reset is asserted:
  - score = 0, hit_q = 3'b111, state = IDLE, conv_src = 0, bcd_disp = 16'h0000, refresh counter = 0.
  - Outputs: busy = 0, bcd_valid = 1, digit_an = 4'b1110, seg = 7'h40.
  - Because hit_q resets to all ones, hits already held high at reset release are not counted.
- Hit scoring:
  - hit_q registers hit each cycle.
  - new = hit & ~hit_q (rising edges only).
  - inc = popcount(new), range 0..3.
  - score <= min(score + inc, MAX_SCORE). Compute in SCORE_W+1 bits so the compare happens before truncation.
  - clr_score has priority over inc: that cycle score <= 0 and any edges are discarded. hit_q still updates.
  - Once at MAX_SCORE, further hits leave score unchanged.
- Conversion FSM, states IDLE, LOAD, SHIFT, DONE:
  - IDLE: if score != conv_src, go to LOAD.
  - LOAD (1 cycle): snap <= score, bcd_work <= 0, shift_cnt <= 0.
  - SHIFT (SCORE_W cycles): each cycle, add 3 to every bcd_work nibble >= 5, then shift {bcd_work, snap} left by 1. Leave after shift_cnt = SCORE_W-1.
  - DONE (1 cycle): bcd_disp <= bcd_work, conv_src <= snapshot value, then IDLE.
  - Latency is 16 cycles from the cycle score changes to bcd_disp updating (LOAD 1 + SHIFT 14 + DONE 1, detect registered).
  - If score changes during a conversion, that conversion still completes on its snapshot. IDLE then sees a mismatch and restarts. No aborts.
  - busy = (state != IDLE).
  - bcd_valid = (state == IDLE) && (conv_src == score).
- Display multiplexing:
  - The refresh counter is free-running and wraps.
  - sel = counter[REFRESH_BITS-1 -: 2]; sel 0..3 = ones, tens, hundreds, thousands. The selected anode is driven 0, all others 1.
  - Leading-zero blanking: thousands, hundreds and tens are blanked when that digit and all higher digits are zero. The ones digit is always shown.
  - A blanked digit drives anode 1 and seg 7'h7F.
  - Segment codes (hex, {g..a}): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Any nibble > 9 displays 7'h7F.
  - seg and digit_an are registered outputs and change one cycle after sel changes.
- Reset asserted mid-conversion: all state returns to reset values immediately. The partial result is discarded.

Test Plan:
- Reset release with hit=3'b000, hold 50 cycles -> score=0, bcd_valid=1, busy=0, digit_an cycles 1110 only; other digits blanked with an=1, seg=7F; ones seg=40.
- Single hit[0] pulse 1 cycle, then hit[1] held high 100 cycles -> score 1 then 2. busy high exactly 16 cycles per conversion. bcd_disp=16'h0002 with bcd_valid=1 afterwards.
- hit 000->111 in one cycle -> score +3 in one cycle. Then clr_score coincident with hit 000->001 -> score=0 (edge discarded).
- Preload score to 9998 via 9998 edges (or force), then apply hit 000->111 -> score saturates at 9999, bcd_disp=16'h9999, all four digits lit showing 9 (seg=10).
- Hits on consecutive conversions: edge at cycle 0, another edge at cycle 5 -> first conversion finishes with snapshot 1, then restarts. Final bcd_disp=16'h0002 by cycle 0+32+ margin. busy is never low with bcd_valid=1 in between.
- Assert rst during SHIFT at score=1234 -> all outputs return to reset values at once. After release with hit=000, no score change.
